// File: rtl/rv_core_pkg.sv
// Shared core definitions: datapath width, register-file geometry and the
// writeback grant encoding used by the arbiter and its round-robin unit.
package rv_core_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef enum logic {
      GRANT_ALU = 1'b0,
      GRANT_MEM = 1'b1
   } grant_e;

endpackage : rv_core_pkg

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant between the ALU and load-unit writeback ports.
// Grants are combinational; the last-granted requester is remembered so the
// other one wins the next tie.
//
//   state      | meaning
//   GRANT_ALU  | ALU was granted last, MEM wins the next tie
//   GRANT_MEM  | MEM was granted last (reset value), ALU wins the next tie
module rr_arbiter2
   import rv_core_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic block_i,
   input  logic req_alu_i,
   input  logic req_mem_i,
   output logic gnt_alu_o,
   output logic gnt_mem_o
);

   grant_e last_grant_q;
   grant_e last_grant_d;

   // Grant selection; reset and flush suppress every grant.
   always_comb begin
      gnt_alu_o    = 1'b0;
      gnt_mem_o    = 1'b0;
      last_grant_d = last_grant_q;
      if (!rst && !block_i) begin
         if (req_alu_i && (!req_mem_i || last_grant_q == GRANT_MEM)) begin
            gnt_alu_o    = 1'b1;
            last_grant_d = GRANT_ALU;
         end else if (req_mem_i) begin
            gnt_mem_o    = 1'b1;
            last_grant_d = GRANT_MEM;
         end
      end
   end

   // Remember the winner of each transfer; hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= GRANT_MEM;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule : rr_arbiter2

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU and load-unit results into the single
// register-file write port, and tracks outstanding destination registers
// in a scoreboard used for source-operand hazard detection.
module writeback_arbiter
   import rv_core_pkg::*;
#(
   parameter int XLEN     = rv_core_pkg::XLEN,
   parameter int NUM_REGS = rv_core_pkg::NUM_REGS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issueValid,
   input  logic [REG_ADDR_W-1:0] issueRd,
   input  logic                  aluValid,
   input  logic [REG_ADDR_W-1:0] aluRd,
   input  logic [XLEN-1:0]       aluData,
   output logic                  aluReady,
   input  logic                  memValid,
   input  logic [REG_ADDR_W-1:0] memRd,
   input  logic [XLEN-1:0]       memData,
   output logic                  memReady,
   input  logic                  flush,
   output logic                  rfWriteEnable,
   output logic [REG_ADDR_W-1:0] rfWriteAddress,
   output logic [XLEN-1:0]       rfWriteData,
   input  logic [REG_ADDR_W-1:0] queryAddress1,
   input  logic [REG_ADDR_W-1:0] queryAddress2,
   output logic                  hazard1,
   output logic                  hazard2
);

   logic                  xfer;
   logic                  wr_en;
   logic [REG_ADDR_W-1:0] xfer_rd;
   logic [XLEN-1:0]       xfer_data;
   logic [NUM_REGS-1:0]   pending_q;
   logic [NUM_REGS-1:0]   pending_d;
   logic                  we_q;
   logic [REG_ADDR_W-1:0] waddr_q;
   logic [XLEN-1:0]       wdata_q;

   rr_arbiter2 u_rr (
      .clk       (clk),
      .rst       (rst),
      .block_i   (flush),
      .req_alu_i (aluValid),
      .req_mem_i (memValid),
      .gnt_alu_o (aluReady),
      .gnt_mem_o (memReady)
   );

   // Select the winning request; grants already imply the matching valid.
   always_comb begin
      xfer      = aluReady | memReady;
      xfer_rd   = aluReady ? aluRd   : memRd;
      xfer_data = aluReady ? aluData : memData;
      wr_en     = xfer && (xfer_rd != '0);
   end

   // Scoreboard next state: clear on writeback, then set on issue so a
   // same-cycle set wins; flush wipes everything. x0 never pends.
   always_comb begin
      pending_d = pending_q;
      if (wr_en) begin
         pending_d[xfer_rd] = 1'b0;
      end
      if (issueValid && issueRd != '0) begin
         pending_d[issueRd] = 1'b1;
      end
      if (flush) begin
         pending_d = '0;
      end
      pending_d[0] = 1'b0;
   end

   // Scoreboard and register-file write port registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         we_q      <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
      end else begin
         pending_q <= pending_d;
         we_q      <= wr_en;
         if (wr_en) begin
            waddr_q <= xfer_rd;
            wdata_q <= xfer_data;
         end
      end
   end

   assign rfWriteEnable  = we_q;
   assign rfWriteAddress = waddr_q;
   assign rfWriteData    = wdata_q;
   assign hazard1        = pending_q[queryAddress1];
   assign hazard2        = pending_q[queryAddress2];

endmodule : writeback_arbiter

// File: tb/tb_writeback_arbiter.sv
// Directed vector bench for writeback_arbiter.
module tb_writeback_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        issueValid;
   logic [4:0]  issueRd;
   logic        aluValid;
   logic [4:0]  aluRd;
   logic [31:0] aluData;
   logic        aluReady;
   logic        memValid;
   logic [4:0]  memRd;
   logic [31:0] memData;
   logic        memReady;
   logic        flush;
   logic        rfWriteEnable;
   logic [4:0]  rfWriteAddress;
   logic [31:0] rfWriteData;
   logic [4:0]  queryAddress1;
   logic [4:0]  queryAddress2;
   logic        hazard1;
   logic        hazard2;

   int n_checks = 0;
   int n_fail   = 0;

   writeback_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .issueValid     (issueValid),
      .issueRd        (issueRd),
      .aluValid       (aluValid),
      .aluRd          (aluRd),
      .aluData        (aluData),
      .aluReady       (aluReady),
      .memValid       (memValid),
      .memRd          (memRd),
      .memData        (memData),
      .memReady       (memReady),
      .flush          (flush),
      .rfWriteEnable  (rfWriteEnable),
      .rfWriteAddress (rfWriteAddress),
      .rfWriteData    (rfWriteData),
      .queryAddress1  (queryAddress1),
      .queryAddress2  (queryAddress2),
      .hazard1        (hazard1),
      .hazard2        (hazard2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, flush, iv;
      logic [4:0]  ird;
      logic        av;
      logic [4:0]  ard;
      logic [31:0] ad;
      logic        mv;
      logic [4:0]  mrd;
      logic [31:0] md;
      logic [4:0]  q1, q2;
      logic        e_ar, e_mr, e_we;
      logic [4:0]  e_wa;
      logic [31:0] e_wd;
      logic        e_h1, e_h2;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic rs, input logic fl, input logic iv, input logic [4:0] ird,
      input logic av, input logic [4:0] ard, input logic [31:0] ad,
      input logic mv, input logic [4:0] mrd, input logic [31:0] md,
      input logic [4:0] q1, input logic [4:0] q2,
      input logic ear, input logic emr, input logic ewe,
      input logic [4:0] ewa, input logic [31:0] ewd,
      input logic eh1, input logic eh2);
      vec_t v;
      v.rst = rs; v.flush = fl; v.iv = iv; v.ird = ird;
      v.av = av; v.ard = ard; v.ad = ad;
      v.mv = mv; v.mrd = mrd; v.md = md;
      v.q1 = q1; v.q2 = q2;
      v.e_ar = ear; v.e_mr = emr; v.e_we = ewe;
      v.e_wa = ewa; v.e_wd = ewd; v.e_h1 = eh1; v.e_h2 = eh2;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
      end
   endtask

   initial begin
      // Reset with both requesters asserting: no grants while in reset.
      rst = 1'b1; flush = 1'b0; issueValid = 1'b0; issueRd = '0;
      aluValid = 1'b1; aluRd = 5'd5; aluData = 32'h1;
      memValid = 1'b1; memRd = 5'd6; memData = 32'h2;
      queryAddress1 = 5'd5; queryAddress2 = 5'd6;
      @(posedge clk); @(posedge clk); @(negedge clk); #1;
      check("rst_aluReady", {31'd0, aluReady}, 32'd0);
      check("rst_memReady", {31'd0, memReady}, 32'd0);
      check("rst_we",       {31'd0, rfWriteEnable}, 32'd0);
      check("rst_addr",     {27'd0, rfWriteAddress}, 32'd0);
      check("rst_data",     rfWriteData, 32'd0);
      check("rst_hazard1",  {31'd0, hazard1}, 32'd0);

      //            rs fl iv ird  av ard ad            mv mrd md            q1  q2   ar mr we wa  wd            h1 h2
      vecs.push_back(mk(0,0,0,5'd0, 1,5'd5,32'hA5,        1,5'd6,32'hB6,        5'd0,5'd0, 1,0,0,5'd0, 32'h0,        0,0)); // tie after reset: ALU
      vecs.push_back(mk(0,0,0,5'd0, 0,5'd0,32'h0,         1,5'd6,32'hB6,        5'd0,5'd0, 0,1,1,5'd5, 32'hA5,       0,0)); // MEM next
      vecs.push_back(mk(0,0,0,5'd0, 0,5'd0,32'h0,         1,5'd10,32'hDEADBEEF, 5'd0,5'd0, 0,1,1,5'd6, 32'hB6,       0,0)); // only MEM
      vecs.push_back(mk(0,0,0,5'd0, 0,5'd0,32'h0,         0,5'd0,32'h0,         5'd0,5'd0, 0,0,1,5'd10,32'hDEADBEEF, 0,0));
      vecs.push_back(mk(0,0,0,5'd0, 0,5'd0,32'h0,         0,5'd0,32'h0,         5'd0,5'd0, 0,0,0,5'd10,32'hDEADBEEF, 0,0)); // hold
      vecs.push_back(mk(0,0,1,5'd7, 0,5'd0,32'h0,         0,5'd0,32'h0,         5'd7,5'd0, 0,0,0,5'd10,32'hDEADBEEF, 0,0)); // issue x7
      vecs.push_back(mk(0,0,0,5'd0, 1,5'd7,32'h77,        0,5'd0,32'h0,         5'd7,5'd0, 1,0,0,5'd10,32'hDEADBEEF, 1,0)); // x7 pending, ALU writes it
      vecs.push_back(mk(0,0,0,5'd0, 0,5'd0,32'h0,         0,5'd0,32'h0,         5'd7,5'd0, 0,0,1,5'd7, 32'h77,       0,0)); // cleared
      vecs.push_back(mk(0,0,1,5'd3, 1,5'd3,32'h33,        0,5'd0,32'h0,         5'd3,5'd0, 1,0,0,5'd7, 32'h77,       0,0)); // set & clear x3
      vecs.push_back(mk(0,0,0,5'd0, 0,5'd0,32'h0,         0,5'd0,32'h0,         5'd3,5'd0, 0,0,1,5'd3, 32'h33,       1,0)); // set wins
      vecs.push_back(mk(0,0,0,5'd0, 1,5'd0,32'h1234,      0,5'd0,32'h0,         5'd3,5'd0, 1,0,0,5'd3, 32'h33,       1,0)); // Rd=0 write
      vecs.push_back(mk(0,0,0,5'd0, 0,5'd0,32'h0,         0,5'd0,32'h0,         5'd3,5'd0, 0,0,0,5'd3, 32'h33,       1,0)); // dropped
      vecs.push_back(mk(0,0,1,5'd4, 0,5'd0,32'h0,         0,5'd0,32'h0,         5'd3,5'd0, 0,0,0,5'd3, 32'h33,       1,0));
      vecs.push_back(mk(0,0,1,5'd9, 0,5'd0,32'h0,         0,5'd0,32'h0,         5'd4,5'd9, 0,0,0,5'd3, 32'h33,       1,0));
      vecs.push_back(mk(0,1,1,5'd15,1,5'd12,32'hC,        1,5'd13,32'hD,        5'd4,5'd9, 0,0,0,5'd3, 32'h33,       1,1)); // flush
      vecs.push_back(mk(0,0,0,5'd0, 1,5'd12,32'hC,        1,5'd13,32'hD,        5'd4,5'd9, 0,1,0,5'd3, 32'h33,       0,0)); // last=ALU kept
      vecs.push_back(mk(0,0,0,5'd0, 1,5'd12,32'hC,        0,5'd0,32'h0,         5'd15,5'd3,1,0,1,5'd13,32'hD,        0,0));
      vecs.push_back(mk(0,0,0,5'd0, 0,5'd0,32'h0,         0,5'd0,32'h0,         5'd0,5'd0, 0,0,1,5'd12,32'hC,        0,0));
      vecs.push_back(mk(1,0,1,5'd20,1,5'd20,32'hEE,       1,5'd21,32'hFF,       5'd0,5'd0, 0,0,0,5'd12,32'hC,        0,0)); // mid-run reset
      vecs.push_back(mk(0,0,0,5'd0, 0,5'd0,32'h0,         0,5'd0,32'h0,         5'd20,5'd0,0,0,0,5'd0, 32'h0,        0,0));
      vecs.push_back(mk(0,0,0,5'd0, 1,5'd1,32'h11,        1,5'd2,32'h22,        5'd0,5'd0, 1,0,0,5'd0, 32'h0,        0,0)); // tie -> ALU again

      foreach (vecs[i]) begin
         rst = vecs[i].rst; flush = vecs[i].flush;
         issueValid = vecs[i].iv; issueRd = vecs[i].ird;
         aluValid = vecs[i].av; aluRd = vecs[i].ard; aluData = vecs[i].ad;
         memValid = vecs[i].mv; memRd = vecs[i].mrd; memData = vecs[i].md;
         queryAddress1 = vecs[i].q1; queryAddress2 = vecs[i].q2;
         #1;
         check($sformatf("v%0d_aluReady", i), {31'd0, aluReady},       {31'd0, vecs[i].e_ar});
         check($sformatf("v%0d_memReady", i), {31'd0, memReady},       {31'd0, vecs[i].e_mr});
         check($sformatf("v%0d_we", i),       {31'd0, rfWriteEnable},  {31'd0, vecs[i].e_we});
         check($sformatf("v%0d_addr", i),     {27'd0, rfWriteAddress}, {27'd0, vecs[i].e_wa});
         check($sformatf("v%0d_data", i),     rfWriteData,             vecs[i].e_wd);
         check($sformatf("v%0d_hazard1", i),  {31'd0, hazard1},        {31'd0, vecs[i].e_h1});
         check($sformatf("v%0d_hazard2", i),  {31'd0, hazard2},        {31'd0, vecs[i].e_h2});
         @(negedge clk);
      end

      // Write pulse lasts one cycle: one more idle cycle after the last ALU grant.
      aluValid = 1'b0; memValid = 1'b0; #1;
      check("pulse_we_high", {31'd0, rfWriteEnable}, 32'd1);
      check("pulse_addr",    {27'd0, rfWriteAddress}, 32'd1);
      @(negedge clk); #1;
      check("pulse_we_low",  {31'd0, rfWriteEnable}, 32'd0);
      check("pulse_data",    rfWriteData, 32'h11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_writeback_arbiter

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of a register write.
REQ-002 SHALL have parameter NUM_REGS, default 32, register count; address width 5.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port issueValid  input  1  instruction issued that will write issueRd.
REQ-006 SHALL have port issueRd  input  5  destination register of the issued instruction.
REQ-007 SHALL have port aluValid  input  1  ALU writeback request.
REQ-008 SHALL have port aluRd  input  5  ALU destination register.
REQ-009 SHALL have port aluData  input  XLEN  ALU result.
REQ-010 SHALL have port aluReady  output  1  ALU request granted this cycle.
REQ-011 SHALL have port memValid  input  1  load-unit writeback request.
REQ-012 SHALL have port memRd  input  5  load destination register.
REQ-013 SHALL have port memData  input  XLEN  load result.
REQ-014 SHALL have port memReady  output  1  load request granted this cycle.
REQ-015 SHALL have port flush  input  1  pipeline flush; clears all pending state.
REQ-016 SHALL have port rfWriteEnable  output  1  register-file write enable.
REQ-017 SHALL have port rfWriteAddress  output  5  register-file write address.
REQ-018 SHALL have port rfWriteData  output  XLEN  register-file write data.
REQ-019 SHALL have port queryAddress1  input  5  source register 1 under hazard check.
REQ-020 SHALL have port queryAddress2  input  5  source register 2 under hazard check.
REQ-021 SHALL have port hazard1 / hazard2  output  1 each  source register has an outstanding write.

Function
REQ-022 SHALL keep a one-bit state lastGrant (ALU/MEM) for round-robin arbitration.
REQ-023 SHALL assert exactly one ready when any valid is high: if only one requester is valid, grant it; if both are valid, grant the one that is not lastGrant. No ready when neither is valid.
REQ-024 SHALL drive aluReady/memReady combinationally from the valids and lastGrant; a transfer occurs when valid and ready are both high.
REQ-025 SHALL update lastGrant to the granted requester on every transfer; lastGrant holds when there is no transfer.
REQ-026 SHALL register the transfer into rfWriteEnable/rfWriteAddress/rfWriteData: latency 1 cycle, with rfWriteEnable high for exactly one cycle per transfer.
REQ-027 SHALL, for a transfer with Rd==0, complete the handshake and keep rfWriteEnable low (the write is dropped).
REQ-028 SHALL hold rfWriteAddress/rfWriteData at their last values when rfWriteEnable is low.
REQ-029 SHALL keep a scoreboard pending[NUM_REGS-1:0] with pending[0] constantly 0.
REQ-030 SHALL set pending[issueRd] at the clock edge when issueValid is high and issueRd!=0.
REQ-031 SHALL clear pending[Rd] at the clock edge of a transfer with Rd!=0.
REQ-032 SHALL let set win over clear when the two target the same register in the same cycle.
REQ-033 SHALL compute hazardN = pending[queryAddressN] combinationally; hazardN is 0 for address 0.
REQ-034 SHALL, while flush is high: force both readies to 0, clear all pending bits at the edge, ignore issueValid, leave lastGrant unchanged, and drive rfWriteEnable 0 the following cycle.
REQ-035 SHALL NOT buffer requests; a requester whose ready is low holds valid, Rd and data stable.

Reset
REQ-036 SHALL, on rst high at a clock edge, set rfWriteEnable=0, rfWriteAddress=0, rfWriteData=0, pending=0 and lastGrant=MEM, so that ALU wins the first tie.
REQ-037 SHALL force aluReady=memReady=0 while rst is high; a transfer in flight is discarded, and rfWriteEnable is 0 in the cycle after reset.
REQ-038 SHALL give rst priority over flush, issueValid and transfers.

Structure
REQ-039 SHALL define XLEN, REG_ADDR_W=5, NUM_REGS=32 and the grant encoding (GRANT_ALU=0, GRANT_MEM=1) in a shared package, rv_core_pkg.
REQ-040 SHALL place the two-way round-robin grant logic, including lastGrant, in the sub-module rr_arbiter2; the scoreboard and output register stay in the top module.

Verification
REQ-041 SHALL cover this case: after reset, aluValid=memValid=1, aluRd=5, memRd=6 -> ALU is granted first; rfWriteAddress=5 next cycle, then 6.
REQ-042 SHALL cover this case: only memValid, memRd=10, memData=0xDEADBEEF -> memReady is high the same cycle; one cycle later rfWriteEnable=1, address 10, data 0xDEADBEEF.
REQ-043 SHALL cover this case: issueValid with issueRd=7, then queryAddress1=7 -> hazard1=1 until the cycle after the aluRd=7 transfer, after which it is 0.
REQ-044 SHALL cover this case: issueValid with issueRd=3 and an ALU transfer to Rd=3 in the same cycle -> rfWriteEnable for 3 occurs and hazard for 3 remains 1.
REQ-045 SHALL cover this case: aluValid with aluRd=0, aluData=0x1234 -> aluReady=1, rfWriteEnable stays 0, hazard for address 0 stays 0.
REQ-046 SHALL cover this case: pending bits for 4 and 9 set, then flush=1 with both valids high -> no readies, pending=0 next cycle, rfWriteEnable=0.
